// File: rtl/pc_fetch_pkg.sv
// Shared CPU constants for the fetch stage.
//   CPU_RESET_PC  : PC value loaded on reset
//   CPU_NOP_INSTR : instruction word injected into IF/ID on flush
//   fetch_state_t : redirect FSM encoding (IDLE = no pending target,
//                   PEND = deferred ID-stage target held)
package pc_fetch_pkg;

  localparam logic [31:0] CPU_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] CPU_NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_sel.sv
// Combinational next-PC selection.
// Ports:
//   i_pc, i_pc_plus4          : current PC and PC+4
//   i_pc_br, i_pc_jr, i_pc_j  : branch / register / jump targets
//   i_pend_tgt                : deferred ID-stage target
//   i_br_taken, i_jr, i_jump  : redirect requests (priority br > jr > jump)
//   i_stall                   : hazard hold
//   i_state                   : redirect FSM state
//   o_next_pc                 : PC to load on the next edge
//   o_redirect                : 1 when o_next_pc is a taken redirect
module pc_sel
  import pc_fetch_pkg::*;
(
  input  logic [31:0]  i_pc,
  input  logic [31:0]  i_pc_plus4,
  input  logic [31:0]  i_pc_br,
  input  logic [31:0]  i_pc_jr,
  input  logic [31:0]  i_pc_j,
  input  logic [31:0]  i_pend_tgt,
  input  logic         i_br_taken,
  input  logic         i_jr,
  input  logic         i_jump,
  input  logic         i_stall,
  input  fetch_state_t i_state,
  output logic [31:0]  o_next_pc,
  output logic         o_redirect
);

  always_comb begin
    o_next_pc  = i_pc;
    o_redirect = 1'b0;
    if (i_br_taken) begin
      // EX-stage branch beats stall and any pending ID-stage target.
      o_next_pc  = i_pc_br;
      o_redirect = 1'b1;
    end else if (i_state == PEND) begin
      // While pending, new jr/jump are ignored; release on stall drop.
      if (!i_stall) begin
        o_next_pc  = i_pend_tgt;
        o_redirect = 1'b1;
      end
    end else if (!i_stall) begin
      if (i_jr) begin
        o_next_pc  = i_pc_jr;
        o_redirect = 1'b1;
      end else if (i_jump) begin
        o_next_pc  = i_pc_j;
        o_redirect = 1'b1;
      end else begin
        o_next_pc  = i_pc_plus4;
      end
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register,
// deferred-redirect FSM and saturating redirect counter.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   stall             : hazard hold of PC and IF/ID
//   br_taken, pc_br   : EX-stage taken branch and its target
//   jump, pc_j        : ID-stage J/JAL and its target
//   jr, pc_jr         : ID-stage JR/JALR and its target
//   imem_rdata        : combinational instruction memory data
//   imem_addr         : current PC
//   if_id_instr       : registered instruction
//   if_id_pc_plus     : registered PC+4 (target on flush)
//   if_id_valid       : 0 marks a bubble
//   flush_cnt         : saturating count of redirects since reset
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = CPU_RESET_PC,
  parameter logic [31:0] NOP_INSTR = CPU_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] pc_br,
  input  logic        jump,
  input  logic [31:0] pc_j,
  input  logic        jr,
  input  logic [31:0] pc_jr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus,
  output logic        if_id_valid,
  output logic [15:0] flush_cnt
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_pend_tgt;
  logic [31:0]  r_instr;
  logic [31:0]  r_pc_plus;
  logic         r_valid;
  logic [15:0]  r_flush_cnt;

  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_next_pc;
  logic         w_redirect;
  logic         w_capture;

  assign w_pc_plus4 = r_pc + 32'd4;

  pc_sel u_pc_sel (
    .i_pc       (r_pc),
    .i_pc_plus4 (w_pc_plus4),
    .i_pc_br    (pc_br),
    .i_pc_jr    (pc_jr),
    .i_pc_j     (pc_j),
    .i_pend_tgt (r_pend_tgt),
    .i_br_taken (br_taken),
    .i_jr       (jr),
    .i_jump     (jump),
    .i_stall    (stall),
    .i_state    (r_state),
    .o_next_pc  (w_next_pc),
    .o_redirect (w_redirect)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!br_taken && stall && (jr || jump)) begin
          w_capture   = 1'b1;
          w_state_nxt = PEND;
        end
      end
      PEND: begin
        if (br_taken || !stall) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_pend_tgt  <= '0;
      r_instr     <= NOP_INSTR;
      r_pc_plus   <= RESET_PC;
      r_valid     <= 1'b0;
      r_flush_cnt <= '0;
    end else begin
      // pc_sel returns r_pc when holding, so PC loads unconditionally.
      r_pc <= w_next_pc;
      if (w_capture) r_pend_tgt <= jr ? pc_jr : pc_j;
      if (w_redirect) begin
        r_instr   <= NOP_INSTR;
        r_pc_plus <= w_next_pc;
        r_valid   <= 1'b0;
        if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 16'd1;
      end else if (!stall) begin
        r_instr   <= imem_rdata;
        r_pc_plus <= w_pc_plus4;
        r_valid   <= 1'b1;
      end
    end
  end

  assign imem_addr     = r_pc;
  assign if_id_instr   = r_instr;
  assign if_id_pc_plus = r_pc_plus;
  assign if_id_valid   = r_valid;
  assign flush_cnt     = r_flush_cnt;

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;
  import pc_fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, br_taken, jump, jr;
  logic [31:0] pc_br, pc_j, pc_jr, imem_rdata, imem_addr;
  logic [31:0] if_id_instr, if_id_pc_plus;
  logic        if_id_valid;
  logic [15:0] flush_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word = bitwise inverse of its address.
  assign imem_rdata = ~imem_addr;

  pc_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .br_taken      (br_taken),
    .pc_br         (pc_br),
    .jump          (jump),
    .pc_j          (pc_j),
    .jr            (jr),
    .pc_jr         (pc_jr),
    .imem_rdata    (imem_rdata),
    .imem_addr     (imem_addr),
    .if_id_instr   (if_id_instr),
    .if_id_pc_plus (if_id_pc_plus),
    .if_id_valid   (if_id_valid),
    .flush_cnt     (flush_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_if(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] pcp, input logic vld, input logic [15:0] fc);
    chk({tag, "_pc"},    imem_addr, pc);
    chk({tag, "_instr"}, if_id_instr, instr);
    chk({tag, "_pcp"},   if_id_pc_plus, pcp);
    chk({tag, "_vld"},   {31'b0, if_id_valid}, {31'b0, vld});
    chk({tag, "_fcnt"},  {16'b0, flush_cnt}, {16'b0, fc});
  endtask

  task automatic chk_st(input string tag, input logic exp);
    chk(tag, {31'b0, dut.r_state}, {31'b0, exp});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; jump = 1'b0; jr = 1'b0;
    pc_br = '0; pc_j = '0; pc_jr = '0;

    // Reset
    tick();
    chk_if("rst", 32'h0, NOP, 32'h0, 1'b0, 16'd0);
    chk_st("rst_st", 1'b0);
    rst = 1'b0;

    // Free run
    tick(); chk_if("fr1", 32'h4, ~32'h0, 32'h4, 1'b1, 16'd0);
    tick(); chk_if("fr2", 32'h8, ~32'h4, 32'h8, 1'b1, 16'd0);
    tick(); tick(); chk(  "fr4_pc", imem_addr, 32'h10);

    // Branch at PC=0x10
    br_taken = 1'b1; pc_br = 32'h40;
    tick(); chk_if("br", 32'h40, NOP, 32'h40, 1'b0, 16'd1);
    br_taken = 1'b0;

    // Jump to 0x20 then all three redirects together
    jump = 1'b1; pc_j = 32'h20;
    tick(); chk_if("j20", 32'h20, NOP, 32'h20, 1'b0, 16'd2);
    br_taken = 1'b1; pc_br = 32'h80; jr = 1'b1; pc_jr = 32'h100; pc_j = 32'h200;
    tick(); chk_if("prio3", 32'h80, NOP, 32'h80, 1'b0, 16'd3);
    br_taken = 1'b0;
    tick(); chk(  "prio_jr_pc", imem_addr, 32'h100);
    jr = 1'b0; jump = 1'b0;
    tick(); chk_if("fr5", 32'h104, ~32'h100, 32'h104, 1'b1, 16'd4);

    // Stalled jump deferred, then released
    stall = 1'b1; jump = 1'b1; pc_j = 32'h300;
    tick(); chk_if("st1", 32'h104, ~32'h100, 32'h104, 1'b1, 16'd4);
    chk_st("st1_st", 1'b1);
    pc_j = 32'h999;
    tick(); chk_if("st2", 32'h104, ~32'h100, 32'h104, 1'b1, 16'd4);
    chk_st("st2_st", 1'b1);
    stall = 1'b0; jump = 1'b0;
    tick(); chk_if("rel", 32'h300, NOP, 32'h300, 1'b0, 16'd5);
    chk_st("rel_st", 1'b0);

    // Pending target discarded by branch under stall
    stall = 1'b1; jr = 1'b1; pc_jr = 32'h300;
    tick(); chk(  "pend2_pc", imem_addr, 32'h300);
    chk_st("pend2_st", 1'b1);
    jr = 1'b0; br_taken = 1'b1; pc_br = 32'h500;
    tick(); chk_if("brpend", 32'h500, NOP, 32'h500, 1'b0, 16'd6);
    chk_st("brpend_st", 1'b0);
    stall = 1'b0; br_taken = 1'b0;
    tick(); chk_if("after", 32'h504, ~32'h500, 32'h504, 1'b1, 16'd6);

    // Plain stall holds everything
    stall = 1'b1;
    tick(); chk_if("hold", 32'h504, ~32'h500, 32'h504, 1'b1, 16'd6);
    stall = 1'b0;

    // Reset dominates mid-PEND with branch
    stall = 1'b1; jump = 1'b1; pc_j = 32'h700;
    tick(); chk_st("pend3_st", 1'b1);
    jump = 1'b0; rst = 1'b1; br_taken = 1'b1; pc_br = 32'h800;
    tick(); chk_if("rstdom", 32'h0, NOP, 32'h0, 1'b0, 16'd0);
    chk_st("rstdom_st", 1'b0);
    rst = 1'b0; br_taken = 1'b0; stall = 1'b0;

    // PC wrap
    jump = 1'b1; pc_j = 32'hFFFF_FFFC;
    tick(); chk_if("wrapj", 32'hFFFF_FFFC, NOP, 32'hFFFF_FFFC, 1'b0, 16'd1);
    jump = 1'b0;
    tick(); chk_if("wrap", 32'h0, 32'h0000_0003, 32'h0, 1'b1, 16'd1);

    // Counter saturation
    jump = 1'b1; pc_j = 32'h1000;
    for (int unsigned i = 0; i < 65534; i++) tick();
    chk("sat_full", {16'b0, flush_cnt}, 32'h0000_FFFF);
    tick();
    chk("sat_hold", {16'b0, flush_cnt}, 32'h0000_FFFF);
    chk("sat_pc", imem_addr, 32'h1000);
    jump = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, is the instruction word injected into IF/ID on flush.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard-unit hold; freezes PC and IF/ID.
REQ-006 br_taken  input  1  EX-stage branch resolved taken.
REQ-007 pc_br  input  32  branch target: sign-extended immediate shifted left 2, plus PC+4.
REQ-008 jump  input  1  ID-stage J/JAL decoded.
REQ-009 pc_j  input  32  jump target: {PC+4[31:28], instr[25:0], 2'b00}.
REQ-010 jr  input  1  ID-stage JR/JALR decoded.
REQ-011 pc_jr  input  32  register target for JR/JALR.
REQ-012 imem_rdata  input  32  combinational instruction-memory read data for imem_addr.
REQ-013 imem_addr  output  32  current PC, driven to instruction memory.
REQ-014 if_id_instr  output  32  registered fetched instruction.
REQ-015 if_id_pc_plus  output  32  registered PC+4 of if_id_instr.
REQ-016 if_id_valid  output  1  1 = if_id_instr is a real instruction; 0 = bubble.
REQ-017 flush_cnt  output  16  count of redirects taken since reset.

Function
REQ-018 pc_fetch SHALL hold PC in a 32-bit register; imem_addr SHALL equal PC combinationally.
REQ-019 With no stall and no redirect, next PC SHALL be PC+4 (mod 2^32, wrap without flag), and IF/ID SHALL load {imem_rdata, PC+4, valid=1}.
REQ-020 Redirect priority SHALL be br_taken > jr > jump; exactly one target is selected per cycle.
REQ-021 A taken redirect SHALL load PC with the selected target and load IF/ID with {NOP_INSTR, target, valid=0} on the same edge (1-cycle flush, no delay slot).
REQ-022 br_taken SHALL override stall: PC redirects and IF/ID flushes even when stall=1.
REQ-023 With stall=1 and no br_taken, PC and IF/ID SHALL hold; an asserted jr/jump SHALL be captured into pend_tgt and the FSM SHALL move IDLE->PEND.
REQ-024 FSM states: IDLE (no pending redirect) and PEND (pend_tgt holds a deferred ID-stage target).
REQ-025 In PEND with stall=0 and no br_taken, PC SHALL load pend_tgt, IF/ID SHALL flush, and the FSM SHALL return to IDLE.
REQ-026 In PEND, br_taken SHALL discard pend_tgt, redirect to pc_br, and return to IDLE.
REQ-027 In PEND with stall=1, pend_tgt SHALL be held; new jr/jump SHALL be ignored.
REQ-028 flush_cnt SHALL increment by 1 on every edge that performs a redirect and SHALL saturate at 16'hFFFF.
REQ-029 Targets SHALL be used unmodified; alignment checking is out of scope.

Reset
REQ-030 On rst=1 at a rising edge: PC=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc_plus=RESET_PC, if_id_valid=0, flush_cnt=0, FSM=IDLE, pend_tgt=0.
REQ-031 rst SHALL dominate all other inputs, including mid-PEND and same-cycle br_taken.

Structure
REQ-032 RESET_PC, NOP_INSTR and the FSM state encoding (IDLE=1'b0, PEND=1'b1) SHALL live in the shared CPU constants package.
REQ-033 Next-PC selection SHALL be a combinational sub-module pc_sel (inputs: PC+4, targets, valid flags, pending state; output: next PC and redirect flag); IF/ID register, FSM and counter remain in pc_fetch.

Verification
REQ-034 Reset then 3 free-run cycles -> imem_addr 0x0, 0x4, 0x8; if_id_valid 0,1,1.
REQ-035 PC=0x10, br_taken=1, pc_br=0x40 -> next imem_addr=0x40, if_id_valid=0, if_id_instr=NOP_INSTR, flush_cnt=1.
REQ-036 PC=0x20, br_taken=1 (pc_br=0x80), jr=1 (pc_jr=0x100), jump=1 (pc_j=0x200) in the same cycle -> next PC=0x80.
REQ-037 stall=1 with jump=1, pc_j=0x300 for 2 cycles, then stall=0 -> PC held 2 cycles, then 0x300, FSM PEND->IDLE, one flush.
REQ-038 PEND holding 0x300, stall=1, br_taken=1, pc_br=0x500 -> PC=0x500, FSM=IDLE, 0x300 never fetched.
REQ-039 PC=0xFFFF_FFFC free-run -> next PC=0x0; flush_cnt preloaded to 0xFFFF plus redirect -> stays 0xFFFF.
